fetch_bht: RTL and testbench
============================

FETCH_BHT -- requirements
Module: fetch_bht

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of BHT/BTB entries (power of two); IDX_W = log2(ENTRIES).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: fetch advance enable from the hazard unit; 0 means stall.
REQ-006 The block SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32): mispredict/jump correction from execute.
REQ-007 The block SHALL have ports upd_valid (input, 1), upd_pc (input, 32), upd_taken (input, 1) and upd_target (input, 32): resolved-branch training.
REQ-008 The block SHALL have port pc, output, 32 bits: current fetch address to instruction memory.
REQ-009 The block SHALL have port pc_plus4, output, 32 bits: pc + 4, wrapping modulo 2^32.
REQ-010 The block SHALL have ports pred_taken (output, 1) and bht_state (output, 2): the prediction for pc, fed to the stage-1 register.

Function
REQ-011 The table SHALL hold, per entry: valid, tag = pc[31:IDX_W+2], target[31:0] and a 2-bit counter; index = pc[IDX_W+1:2].
REQ-012 Lookup SHALL be combinational on pc; hit = valid && tag match.
REQ-013 bht_state SHALL equal the entry counter on hit, otherwise 2'b00; pred_taken SHALL equal hit && counter[1].
REQ-014 Counter encoding SHALL be: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-015 Next-PC priority SHALL be: redirect_valid -> redirect_pc (ignores en); else en=0 -> hold pc; else pred_taken -> entry target; else pc_plus4.
REQ-016 A redirect SHALL take effect on the next edge: pc equals redirect_pc one cycle after redirect_valid is sampled.
REQ-017 Training on upd_valid with tag hit at upd_pc index SHALL saturate the counter: +1 if upd_taken (max 11), -1 otherwise (min 00); target SHALL be overwritten with upd_target only when upd_taken.
REQ-018 Training on tag miss with upd_taken=1 SHALL allocate: valid=1, tag from upd_pc, target=upd_target, counter=10, evicting any occupant.
REQ-019 Training on tag miss with upd_taken=0 SHALL leave the table unchanged.
REQ-020 Training SHALL proceed regardless of en and redirect_valid.
REQ-021 When lookup and training address the same index in one cycle, lookup SHALL see the pre-update entry; the update SHALL be visible the following cycle.

Reset
REQ-022 On a rising clk edge with rst_n=0: pc SHALL load RESET_PC, and every entry SHALL clear valid=0, counter=00, tag=0, target=0.
REQ-023 Reset SHALL override redirect, training and en; after reset, pred_taken=0, bht_state=00, pc_plus4=RESET_PC+4.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight training of that cycle.

Configuration
REQ-025 Macro BHT_PREDICT_EN SHALL select prediction: defined -> behaviour per REQ-011..REQ-021.
REQ-026 Without BHT_PREDICT_EN the table SHALL not be built; pred_taken SHALL be 0, bht_state SHALL be 00, upd_* SHALL be ignored, next PC SHALL be redirect_pc or pc_plus4 or hold per REQ-015.

Verification
REQ-027 Reset with RESET_PC=0, en=1, no redirects, 3 cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; bht_state=00 throughout.
REQ-028 upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100; later pc=0x40 -> bht_state=10, pred_taken=1, next pc=0x100.
REQ-029 Two further taken updates at 0x40 then three not-taken -> counter 11 (saturated) then 00; pc=0x40 predicts not-taken, next pc=0x44.
REQ-030 en=0 and redirect_valid=1, redirect_pc=0x200 in same cycle -> pc=0x200 next cycle; en=0 alone -> pc held.
REQ-031 Aliasing: allocate 0x40 (ENTRIES=16), then taken update at 0x440 -> pc=0x40 misses (bht_state=00), pc=0x440 hits with new target.
REQ-032 pc=0xFFFF_FFFC, en=1, miss -> pc_plus4=0x0, next pc=0x0; without BHT_PREDICT_EN, REQ-028 stimulus yields pred_taken=0, next pc=0x44.

Source files
------------

// File: rtl/fetch_bht.sv
// fetch_bht: fetch PC register with a direct-mapped branch history / target table (BHT/BTB).
// Latency: lookup is combinational on pc; redirects, predictions and training take effect on the next edge.
// Backpressure: en=0 holds pc (a redirect still wins); training is never stalled.
// Optional feature macro: BHT_PREDICT_EN builds the table; without it pc runs sequentially.
module fetch_bht #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pred_taken,
  output logic [1:0]  bht_state
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pred_target;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef BHT_PREDICT_EN
  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [IDX_W-1:0] look_idx, upd_idx;
  logic             look_hit, upd_hit;
  logic             unused_upd_lsb;

  assign look_idx = pc_q[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == pc_q[31:IDX_W+2]);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_pc[31:IDX_W+2]);

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign bht_state   = look_hit ? ctr_q[look_idx] : 2'b00;
  assign pred_taken  = look_hit && ctr_q[look_idx][1];
  assign pred_target = tgt_q[look_idx];

  // Byte-offset bits of the training address do not select anything.
  assign unused_upd_lsb = ^upd_pc[1:0];

  // Training: saturate the counter on a hit, allocate on a taken miss, ignore a not-taken miss.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          tgt_d[upd_idx] = upd_target;
        end else begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_pc[31:IDX_W+2];
        tgt_d[upd_idx]   = upd_target;
        ctr_d[upd_idx]   = 2'b10;
      end
    end
  end

  // Table state; reset wipes every entry and drops any training of that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end
`else
  logic unused_upd;

  assign pred_taken  = 1'b0;
  assign bht_state   = 2'b00;
  assign pred_target = 32'h0;
  // Training inputs have no effect when the table is not built.
  assign unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
`endif

  // Next-PC priority: redirect, stall, predicted target, sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!en) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_bht.sv
// Scoreboard bench for fetch_bht: a driver issues one stimulus per cycle and pushes the
// expected outputs for that cycle; a monitor samples the DUT and compares against the queue.
// The reference model tracks the fetch PC and a per-slot record of the last allocated branch.
module tb_fetch_bht;

  localparam int          ENTRIES  = 16;
  localparam int          IDX_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic [31:0] pc, pc_plus4;
  logic        pred_taken;
  logic [1:0]  bht_state;

  fetch_bht #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken), .bht_state(bht_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] pc;
    bit [31:0] p4;
    bit        pt;
    bit [1:0]  st;
    int        cyc;
  } exp_t;

  typedef struct {
    bit        v;
    bit [31:0] addr;   // full branch address; tag match compares the bits above the index
    bit [31:0] tgt;
    int        ctr;    // 0..3 confidence, taken when >= 2
  } ent_t;

  exp_t      sb[$];
  ent_t      tbl[ENTRIES];
  bit [31:0] m_pc;
  bit        known = 1'b0;
  bit        done = 1'b0;
  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc = 0;

  function automatic int slot(input bit [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  function automatic bit same_tag(input bit [31:0] a, input bit [31:0] b);
    return (a >> (IDX_W + 2)) == (b >> (IDX_W + 2));
  endfunction

  function automatic bit m_hit(input bit [31:0] a);
`ifdef BHT_PREDICT_EN
    return tbl[slot(a)].v && same_tag(tbl[slot(a)].addr, a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) tbl[i] = '{v: 1'b0, addr: 32'h0, tgt: 32'h0, ctr: 0};
    m_pc  = RESET_PC;
    known = 1'b1;
  endtask

  task automatic step(input bit r, input bit e, input bit rv, input bit [31:0] rp,
                      input bit uv, input bit [31:0] up, input bit ut, input bit [31:0] utg);
    exp_t x;
    bit   h, p;
    bit [31:0] nxt;
    @(negedge clk);
    cyc++;
    h = m_hit(m_pc);
    p = h && (tbl[slot(m_pc)].ctr >= 2);
    if (known) begin
      x.pc = m_pc;
      x.p4 = m_pc + 32'd4;
      x.pt = p;
      x.st = h ? 2'(tbl[slot(m_pc)].ctr) : 2'b00;
      x.cyc = cyc;
      sb.push_back(x);
    end
    rst_n = r; en = e; redirect_valid = rv; redirect_pc = rp;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    if (!r) begin
      m_reset();
    end else if (known) begin
      if (rv)      nxt = rp;
      else if (!e) nxt = m_pc;
      else if (p)  nxt = tbl[slot(m_pc)].tgt;
      else         nxt = m_pc + 32'd4;
`ifdef BHT_PREDICT_EN
      if (uv) begin
        if (m_hit(up)) begin
          if (ut) begin
            tbl[slot(up)].ctr = (tbl[slot(up)].ctr < 3) ? tbl[slot(up)].ctr + 1 : 3;
            tbl[slot(up)].tgt = utg;
          end else begin
            tbl[slot(up)].ctr = (tbl[slot(up)].ctr > 0) ? tbl[slot(up)].ctr - 1 : 0;
          end
        end else if (ut) begin
          tbl[slot(up)] = '{v: 1'b1, addr: up, tgt: utg, ctr: 2};
        end
      end
`endif
      m_pc = nxt;
    end
  endtask

  // Shorthands for the directed part.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump(input bit [31:0] a);
    step(1, 1, 1, a, 0, 0, 0, 0);
  endtask
  task automatic train(input bit [31:0] a, input bit t, input bit [31:0] g);
    step(1, 0, 0, 0, 1, a, t, g);
  endtask

  task automatic check(input string nm, input bit [31:0] got, input bit [31:0] want, input int c);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, got, want);
    end
  endtask

  // Monitor: outputs depend only on registered state, so sample mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("pc", pc, x.pc, x.cyc);
        check("pc_plus4", pc_plus4, x.p4, x.cyc);
        check("pred_taken", {31'h0, pred_taken}, {31'h0, x.pt}, x.cyc);
        check("bht_state", {30'h0, bht_state}, {30'h0, x.st}, x.cyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "timeout");
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    bit [31:0] a, b;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h123, 1, 32'h0, 1, 32'h80);   // reset overrides everything
    run(4);                                         // 0,4,8,C sequence
    train(32'h40, 1, 32'h100);                      // allocate weak-taken
    jump(32'h40);
    run(3);                                         // predicts 0x100
    train(32'h40, 1, 32'h100);
    train(32'h40, 1, 32'h100);                      // saturated at 11
    jump(32'h40);
    step(1, 0, 0, 0, 0, 0, 0, 0);                   // observe state while held
    train(32'h40, 0, 0);
    train(32'h40, 0, 0);
    train(32'h40, 0, 0);
    train(32'h40, 0, 0);                            // saturated at 00
    jump(32'h40);
    run(2);                                         // not-taken, 0x44
    step(1, 0, 1, 32'h200, 0, 0, 0, 0);             // redirect wins over stall
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);                   // held
    step(0, 1, 0, 0, 0, 0, 0, 0);
    train(32'h40, 1, 32'h100);
    train(32'h440, 1, 32'h300);                     // alias evicts 0x40
    jump(32'h40);
    step(1, 1, 1, 32'h440, 0, 0, 0, 0);
    run(2);
    jump(32'h80);
    step(1, 0, 0, 0, 1, 32'h80, 1, 32'h500);        // same-slot train while looking up
    run(2);
    jump(32'hFFFF_FFFC);
    run(2);                                         // wraps to 0
    step(1, 1, 0, 0, 1, 32'h4, 1, 32'h600);
    step(0, 1, 0, 0, 1, 32'h8, 1, 32'h700);         // training dropped by reset
    jump(32'h8);
    run(2);
    for (int i = 0; i < 500; i++) begin
      a = {($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'h0, 2'b0, 4'($urandom), 2'b00};
      b = {22'h0, 1'($urandom), 7'($urandom), 2'b00};
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, a,
           $urandom_range(0, 1) == 1, b, $urandom_range(0, 2) != 0, {$urandom} & 32'hFFFF_FFFC);
    end
    run(2);
    @(negedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
